// File: rtl/sram_dbuf_ctrl.sv
// Double-buffer controller for SRAMA/B/C ping-pong banks.
// Sequences host fill, bank swap and accelerator tile runs.
//
// Ports:
//   i_clk         clock, rising edge
//   i_rstn        async active-low reset
//   i_start       pulse: begin a run (accepted in IDLE only)
//   i_num_tiles   tiles per run, 0 means 1
//   i_ch_en       channel participation [0]=A [1]=B [2]=C
//   i_host_done   per-channel pulse: host bank finished
//   i_core_done   pulse: accelerator tile finished
//   o_select      bank select bits to the SRAMs
//   o_host_ready  host may access its bank of channel k
//   o_core_start  pulse: accelerator may start a tile
//   o_done        pulse: run complete
//   o_busy        controller not idle
//   o_err         sticky protocol-violation flag
//   o_swap_cnt    swaps since last accepted start
module sram_dbuf_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_tiles,
  input  logic [0:2]       i_ch_en,
  input  logic [0:2]       i_host_done,
  input  logic             i_core_done,
  output logic [0:2]       o_select,
  output logic [0:2]       o_host_ready,
  output logic             o_core_start,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_err,
  output logic [CNT_W-1:0] o_swap_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SWAP,
    S_RUN,
    S_FINAL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [0:2]       ch_en;
  logic [0:2]       hdone;
  logic [CNT_W-1:0] num_tiles;
  logic [CNT_W-1:0] tile_cnt;
  logic [CNT_W-1:0] tile_inc;

  logic       start_acc;
  logic       host_win;
  logic [0:2] host_ok;
  logic [0:2] host_bad;
  logic       core_ok;
  logic       core_bad;
  logic       fill_ok;
  logic       last_tile;
  logic       swapping;

  assign start_acc = i_start
                   & (state == S_IDLE);

  assign host_win = (state == S_FILL)
                  | (state == S_RUN);

  assign o_host_ready = host_win
                      ? (ch_en & ~hdone)
                      : 3'b000;

  // A host pulse is only honoured while
  // its channel is ready; anything else
  // is a violation and leaves hdone alone.
  assign host_ok  = i_host_done
                  & o_host_ready;
  assign host_bad = i_host_done
                  & ~o_host_ready;

  assign core_ok  = i_core_done
                  & (state == S_RUN);
  assign core_bad = i_core_done
                  & (state != S_RUN);

  // Disabled channels count as done, so
  // an empty ch_en swaps straight away.
  assign fill_ok = &(hdone | ~ch_en);

  assign tile_inc  = tile_cnt + 1'b1;
  assign last_tile = (tile_inc == num_tiles);

  // Both SWAP and FINAL flip the banks.
  assign swapping = (state == S_SWAP)
                  | (state == S_FINAL);

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_ok) begin
          state_nxt = S_SWAP;
        end
      end
      S_SWAP: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_core_done) begin
          state_nxt = last_tile
                    ? S_FINAL
                    : S_FILL;
        end
      end
      S_FINAL: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ch_en     <= 3'b000;
      num_tiles <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (start_acc) begin
      ch_en     <= i_ch_en;
      num_tiles <= (i_num_tiles == '0)
                 ? {{(CNT_W-1){1'b0}}, 1'b1}
                 : i_num_tiles;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hdone <= 3'b000;
    end else if (start_acc) begin
      hdone <= 3'b000;
    end else if (state == S_SWAP) begin
      hdone <= 3'b000;
    end else begin
      hdone <= hdone | host_ok;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tile_cnt <= '0;
    end else if (start_acc) begin
      tile_cnt <= '0;
    end else if (core_ok) begin
      tile_cnt <= tile_inc;
    end
  end

  // o_select survives across runs; only
  // reset clears it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_select <= 3'b000;
    end else if (swapping) begin
      o_select <= o_select ^ ch_en;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_swap_cnt <= '0;
    end else if (start_acc) begin
      o_swap_cnt <= '0;
    end else if (swapping) begin
      o_swap_cnt <= o_swap_cnt + 1'b1;
    end
  end

  // Registered so the pulses line up with
  // the new o_select in the next state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_core_start <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_core_start <= (state == S_SWAP);
      o_done       <= (state == S_FINAL);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_err <= 1'b0;
    end else begin
      o_err <= (start_acc ? 1'b0 : o_err)
             | (|host_bad)
             | core_bad;
    end
  end

endmodule

// File: tb/tb_sram_dbuf_ctrl.sv
// Scoreboard bench for sram_dbuf_ctrl.
// Directed runs; pulses checked by a monitor.
module tb_sram_dbuf_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] num;
  logic [0:2]  ch_en;
  logic [0:2]  hd;
  logic        cd;
  logic [0:2]  sel;
  logic [0:2]  rdy;
  logic        cs;
  logic        done;
  logic        busy;
  logic        err;
  logic [15:0] scnt;

  typedef struct packed {
    logic        is_done;
    logic [0:2]  sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_pass;

  sram_dbuf_ctrl #(.CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_num_tiles  (num),
    .i_ch_en      (ch_en),
    .i_host_done  (hd),
    .i_core_done  (cd),
    .o_select     (sel),
    .o_host_ready (rdy),
    .o_core_start (cs),
    .o_done       (done),
    .o_busy       (busy),
    .o_err        (err),
    .o_swap_cnt   (scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  task automatic push(input logic d,
                      input logic [0:2] s,
                      input logic [15:0] c);
    exp_t e;
    e.is_done = d;
    e.sel     = s;
    e.cnt     = c;
    q.push_back(e);
  endtask

  // Monitor: every core_start/done pulse
  // must match the next queued expectation.
  always @(negedge clk) begin
    if (rstn && (cs || done)) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pulse: cs=%0b done=%0b",
                 cs, done);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse", {cs, done, 11'd0, sel, scnt},
            {~e.is_done, e.is_done, 11'd0, e.sel, e.cnt});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [15:0] n,
                           input logic [0:2] en);
    start = 1'b1;
    num   = n;
    ch_en = en;
    step();
    start = 1'b0;
  endtask

  task automatic host(input logic [0:2] b);
    hd = b;
    step();
    hd = 3'b000;
  endtask

  task automatic core();
    cd = 1'b1;
    step();
    cd = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rstn   = 1'b0;
    start  = 1'b0;
    num    = 16'd0;
    ch_en  = 3'b000;
    hd     = 3'b000;
    cd     = 1'b0;
    repeat (2) step();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Basic three-channel, two tiles
    start_run(16'd2, 3'b111);
    chk("s1_rdy0", 32'(rdy), 32'b111);
    chk("s1_busy", 32'(busy), 32'd1);
    host(3'b100);
    chk("s1_rdy1", 32'(rdy), 32'b011);
    host(3'b010);
    push(1'b0, 3'b111, 16'd1);
    host(3'b001);
    chk("s1_lat_t", 32'(cs), 32'd0);
    step();
    chk("s1_lat_t1", 32'(cs), 32'd0);
    step();
    chk("s1_lat_t2", 32'(cs), 32'd1);
    host(3'b100);
    host(3'b010);
    push(1'b0, 3'b000, 16'd2);
    hd = 3'b001;
    cd = 1'b1;
    step();
    hd = 3'b000;
    cd = 1'b0;
    step();
    step();
    push(1'b1, 3'b111, 16'd3);
    core();
    step();
    chk("s1_idle", 32'(busy), 32'd0);
    chk("s1_cnt", 32'(scnt), 32'd3);
    chk("s1_err", 32'(err), 32'd0);
    step();

    // Only SRAMC participates
    start_run(16'd1, 3'b001);
    chk("s2_rdy", 32'(rdy), 32'b001);
    push(1'b0, 3'b110, 16'd1);
    host(3'b001);
    step();
    step();
    push(1'b1, 3'b111, 16'd2);
    core();
    step();
    chk("s2_cnt", 32'(scnt), 32'd2);
    chk("s2_sel", 32'(sel), 32'b111);

    // Protocol errors
    core();
    chk("s3_err_idle", 32'(err), 32'd1);
    chk("s3_busy_idle", 32'(busy), 32'd0);
    start_run(16'd1, 3'b111);
    chk("s3_err_clr", 32'(err), 32'd0);
    host(3'b100);
    host(3'b100);
    chk("s3_err_dbl", 32'(err), 32'd1);
    chk("s3_rdy", 32'(rdy), 32'b011);
    chk("s3_busy", 32'(busy), 32'd1);
    push(1'b0, 3'b000, 16'd1);
    host(3'b010);
    host(3'b001);
    step();
    step();
    push(1'b1, 3'b111, 16'd2);
    core();
    step();
    chk("s3_err_held", 32'(err), 32'd1);

    // Zero tiles, start during RUN ignored
    start_run(16'd0, 3'b111);
    push(1'b0, 3'b000, 16'd1);
    host(3'b111);
    step();
    step();
    start = 1'b1;
    num   = 16'd5;
    step();
    start = 1'b0;
    chk("s4_busy", 32'(busy), 32'd1);
    chk("s4_cnt", 32'(scnt), 32'd1);
    chk("s4_rdy", 32'(rdy), 32'b111);
    push(1'b1, 3'b111, 16'd2);
    core();
    step();
    chk("s4_idle", 32'(busy), 32'd0);

    // Reset in RUN with select 111
    start_run(16'd1, 3'b000);
    push(1'b0, 3'b111, 16'd1);
    step();
    step();
    step();
    chk("s5_sel", 32'(sel), 32'b111);
    chk("s5_run", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("s5_rst_sel", 32'(sel), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_cnt", 32'(scnt), 32'd0);
    chk("s5_rst_misc", {29'd0, cs, done, err}, 32'd0);
    chk("s5_rst_rdy", 32'(rdy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    start_run(16'd1, 3'b111);
    chk("s5_accept", 32'(busy), 32'd1);
    push(1'b0, 3'b111, 16'd1);
    host(3'b111);
    step();
    step();
    push(1'b1, 3'b000, 16'd2);
    core();
    step();
    chk("s5_sel_end", 32'(sel), 32'b000);
    chk("s5_cnt_end", 32'(scnt), 32'd2);

    repeat (3) step();
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_dbuf_ctrl.md
SRAM_DBUF_CTRL -- requirements
Module: sram_dbuf_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of tile count and swap counter.
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse: begin a tiled run.
REQ-005 SHALL have port i_num_tiles  input  CNT_W  tiles in the run, sampled at accepted i_start; 0 treated as 1.
REQ-006 SHALL have port i_ch_en  input  [0:2]  channel participation (0=SRAMA, 1=SRAMB, 2=SRAMC), sampled at accepted i_start.
REQ-007 SHALL have port i_host_done  input  [0:2]  per-channel pulse: host finished its bank of channel k.
REQ-008 SHALL have port i_core_done  input  1  pulse: accelerator finished the current tile.
REQ-009 SHALL have port o_select  output  [0:2]  double-buffer select bits, drive SRAM i_select.
REQ-010 SHALL have port o_host_ready  output  [0:2]  host may access its bank of channel k.
REQ-011 SHALL have port o_core_start  output  1  one-cycle pulse: accelerator may start a tile.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse: run complete.
REQ-013 SHALL have port o_busy  output  1  FSM not in IDLE.
REQ-014 SHALL have port o_err  output  1  sticky protocol-violation flag.
REQ-015 SHALL have port o_swap_cnt  output  CNT_W  number of swaps since last accepted i_start, wraps at 2^CNT_W.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, SWAP, RUN, FINAL.
REQ-017 IDLE: i_start -> FILL; latch ch_en, num_tiles; clear tile count, flags, o_swap_cnt, o_err. i_start outside IDLE ignored, no state change.
REQ-018 SHALL hold a registered per-channel flag hdone[k], set on i_host_done[k] while in FILL or RUN and ch_en[k]=1.
REQ-019 FILL: when hdone[k]=1 for every enabled channel (evaluated on registered flags) -> SWAP next cycle; if no channel enabled, -> SWAP immediately.
REQ-020 SWAP (exactly 1 cycle): toggle o_select[k] for each enabled channel, clear all hdone, increment o_swap_cnt -> RUN.
REQ-021 o_select toggle and o_core_start pulse SHALL both be registered and first visible in the first RUN cycle.
REQ-022 RUN: on i_core_done, increment tile count; if tile count reaches num_tiles -> FINAL, else -> FILL.
REQ-023 FINAL (1 cycle): toggle o_select for enabled channels (host gains access to last SRAMC results), increment o_swap_cnt, -> IDLE; o_done pulse first visible in the IDLE cycle that follows.
REQ-024 o_host_ready[k] = ch_en[k] AND not hdone[k] AND state in {FILL, RUN}; combinational from registered state.
REQ-025 o_busy = 1 in FILL, SWAP, RUN, FINAL.
REQ-026 o_err SHALL set on: i_host_done[k] while hdone[k]=1 or while o_host_ready[k]=0; i_core_done outside RUN; held until next accepted i_start.
REQ-027 Violating pulses SHALL not change hdone, tile count or state.
REQ-028 Simultaneous i_core_done and i_host_done in RUN: both take effect in the same cycle.
REQ-029 o_select SHALL persist across runs (not cleared at i_start).

Reset
REQ-030 Reset SHALL force IDLE, o_select=3'b000, hdone=0, tile count=0, o_swap_cnt=0, o_err=0, o_core_start=0, o_done=0, o_busy=0, o_host_ready=0, asynchronously, mid-operation included.
REQ-031 After reset deassertion, first i_start SHALL be accepted on the next rising edge.

Verification
REQ-032 Basic: ch_en=111, num_tiles=2; host_done 100,010,001 in 3 cycles -> SWAP, o_select=111 with o_core_start; refill, core_done -> o_select=000; core_done -> FINAL, o_select=111, o_done, o_swap_cnt=3.
REQ-033 Partial enable: ch_en=001, num_tiles=1; host_done=001 -> only o_select[2] toggles; o_host_ready[0:1] stay 0; o_swap_cnt=2 at end.
REQ-034 Latency: host_done completing set at edge t -> o_core_start and new o_select visible at t+2 cycles.
REQ-035 Errors: double host_done[0] before swap -> o_err=1, state unchanged; core_done in IDLE -> o_err=1; next i_start clears o_err.
REQ-036 Reset mid-RUN with o_select=111 -> all outputs at reset values immediately, o_select=000.
REQ-037 num_tiles=0 behaves as 1; i_start during RUN ignored, tile count unchanged.
